// File: rtl/arb_pkg.sv
// Shared definitions for the request/grant arbiter and its per-master requester agents.
package arb_pkg;

    // Number of masters sharing the arbitrated bus.
    localparam int NUM_REQ      = 4;

    // Default burst length width: a burst carries 1..2**DEF_BURST_W beats.
    localparam int DEF_BURST_W  = 4;

    // Default number of cycles a requester waits for a grant before giving up.
    localparam int DEF_WAIT_MAX = 64;

    // Default width of the grant-wait counter; must be able to hold DEF_WAIT_MAX.
    localparam int DEF_WAIT_W   = 16;

    // Requester protocol states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_OWN     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_wait_timer.sv
// Grant-wait timer: clearable, enabled up-counter that sticks at WAIT_MAX-1
// and flags expiry while it sits there.
module arb_wait_timer
    import arb_pkg::*;
#(
    parameter int WAIT_MAX = DEF_WAIT_MAX,
    parameter int WAIT_W   = DEF_WAIT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_MAX - 1);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: clear wins over enable; counting stops at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/arb_requester.sv
// Client-side agent for the 4-way arbiter: turns a burst command from the local
// master into a req/gnt handshake, counts out the granted beats, survives
// preemption, inserts a one-cycle release gap and reports done or timeout.
module arb_requester
    import arb_pkg::*;
#(
    parameter int BURST_W  = DEF_BURST_W,
    parameter int WAIT_MAX = DEF_WAIT_MAX,
    parameter int WAIT_W   = DEF_WAIT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [BURST_W-1:0] cmd_len,
    output logic               cmd_ready,
    input  logic               gnt,
    output logic               req,
    output logic               beat,
    output logic               done,
    output logic               err_timeout
);

    arb_state_e         state_q;
    logic [BURST_W-1:0] rem_q;      // beats still owed after the current one
    logic               req_q;
    logic               done_q;
    logic               err_q;

    logic               wait_clr;
    logic               wait_en;
    logic               wait_expire;

    // The wait counter restarts whenever REQ is (re)entered: on command accept
    // and on preemption out of OWN. It only advances while waiting ungranted.
    assign wait_clr = ((state_q == ST_IDLE) && cmd_valid) ||
                      ((state_q == ST_OWN)  && !gnt);
    assign wait_en  = (state_q == ST_REQ) && !gnt;

    arb_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wait_clr),
        .en_i     (wait_en),
        .expire_o (wait_expire)
    );

    // Protocol FSM with registered req/done/err and the remaining-beat count.
    // A grant arriving in the expiry cycle takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rem_q   <= cmd_len;
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt) begin
                        state_q <= ST_OWN;
                    end else if (wait_expire) begin
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (gnt) begin
                        if (rem_q == '0) begin
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_RELEASE;
                        end else begin
                            rem_q <= rem_q - 1'b1;
                        end
                    end else begin
                        // Preempted: keep the remaining count and re-request.
                        state_q <= ST_REQ;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign beat        = (state_q == ST_OWN) && gnt;
    assign req         = req_q;
    assign done        = done_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed reset/corner cases plus randomized grant
// schedules, checked by a transaction-level model through a scoreboard queue.
module tb_arb_requester;

    localparam int BURST_W  = 4;
    localparam int WAIT_MAX = 4;
    localparam int WAIT_W   = 16;
    localparam int NSEG     = 4;
    localparam int VEC_N    = 512;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic [BURST_W-1:0] cmd_len = '0;
    logic               gnt = 1'b0;
    logic               cmd_ready;
    logic               req;
    logic               beat;
    logic               done;
    logic               err_timeout;

    always #5 clk = ~clk;

    arb_requester #(
        .BURST_W  (BURST_W),
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_len     (cmd_len),
        .cmd_ready   (cmd_ready),
        .gnt         (gnt),
        .req         (req),
        .beat        (beat),
        .done        (done),
        .err_timeout (err_timeout)
    );

    // Expected outcome of one command: beats delivered, how it ends, and the
    // cycle (counted from the first cycle after acceptance, =1) of the end pulse.
    typedef struct {
        int nb;
        bit is_err;
        int dur;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    bit   gvec[VEC_N];
    int   pw[NSEG];
    int   ph[NSEG];

    function automatic void chk(string nm, int act, int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endfunction

    // Reference model. The grant schedule after acceptance is: w[0] low cycles,
    // h[0] high, w[1] low, h[1] high, ... A high run that starts while waiting
    // spends its first cycle winning the grant; each further high cycle moves
    // one beat. A low run that interrupts ownership spends its first cycle on
    // the preemption itself, the rest waiting. WAIT_MAX ungranted waiting
    // cycles in a row abort the burst one cycle later.
    function automatic exp_t model(int len, int w[NSEG], int h[NSEG]);
        exp_t e;
        int rem, s, lo, g, b;
        e.len = len; e.nb = 0; e.is_err = 1'b0; e.dur = 0;
        rem = len + 1;
        s   = 1;
        for (int k = 0; k < NSEG; k++) begin
            lo = (k == 0) ? w[k] : w[k] - 1;
            if (lo >= WAIT_MAX) begin
                e.is_err = 1'b1;
                e.dur    = s + WAIT_MAX;
                return e;
            end
            g = s + lo;
            b = (h[k] - 1 < rem) ? h[k] - 1 : rem;
            e.nb += b;
            rem  -= b;
            if (rem == 0) begin
                e.dur = g + b + 1;
                return e;
            end
            s = g + h[k] + 1;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command against a grant schedule. keep_valid holds cmd_valid
    // (with junk lengths) through the burst to show it is ignored.
    task automatic run_cmd(input int len, input bit keep_valid, input int idle);
        exp_t e;
        int   guard;
        int   p;
        e = model(len, pw, ph);
        for (int i = 0; i < VEC_N; i++) gvec[i] = 1'b0;
        p = 1;
        for (int k = 0; k < NSEG; k++) begin
            for (int i = 0; i < pw[k] && p < VEC_N; i++) begin gvec[p] = 1'b0; p++; end
            for (int i = 0; i < ph[k] && p < VEC_N; i++) begin gvec[p] = 1'b1; p++; end
        end
        step();
        cmd_valid = 1'b1;
        cmd_len   = BURST_W'(len);
        gnt       = 1'($urandom_range(0, 1));
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            step();
            guard++;
        end
        if (!cmd_ready) begin
            chk("accept_wait", int'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        for (int idx = 1; idx <= e.dur; idx++) begin
            step();
            gnt       = (idx < e.dur) ? gvec[idx] : 1'($urandom_range(0, 1));
            cmd_valid = keep_valid && ((idx < e.dur) || !e.is_err);
            if (keep_valid) cmd_len = BURST_W'($urandom_range(0, 15));
        end
        for (int i = 0; i < idle; i++) begin
            step();
            cmd_valid = 1'b0;
            gnt       = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: samples mid-cycle, tracks the accepted command and scores it
    // against the head of the expectation queue when done/err_timeout appears.
    bit   m_active = 1'b0;
    int   m_idx    = 0;
    int   m_beats  = 0;
    int   m_last   = -1;
    exp_t me;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_active) begin
                m_idx++;
                if (exp_q.size() == 0) begin
                    chk("queue_empty", exp_q.size(), 1);
                    m_active = 1'b0;
                end else begin
                    me = exp_q[0];
                    if (beat) begin
                        m_beats++;
                        m_last = m_idx;
                    end
                    if (m_idx <= me.dur) begin
                        chk("req", int'(req), int'(m_idx < me.dur));
                        chk("cmd_ready", int'(cmd_ready), int'((m_idx == me.dur) && me.is_err));
                    end
                    if (done || err_timeout) begin
                        chk("end_err", int'(err_timeout), int'(me.is_err));
                        chk("end_done", int'(done), int'(!me.is_err));
                        chk("beats", m_beats, me.nb);
                        chk("duration", m_idx, me.dur);
                        if (done) chk("done_after_last_beat", m_last, m_idx - 1);
                        $display("txn len=%0d beats=%0d end=%s cycles=%0d", me.len, m_beats,
                                 err_timeout ? "timeout" : "done", m_idx);
                        void'(exp_q.pop_front());
                        m_active = 1'b0;
                    end else if (m_idx > me.dur + 8) begin
                        chk("end_pulse_missing", int'(done), 1);
                        void'(exp_q.pop_front());
                        m_active = 1'b0;
                    end
                end
            end else begin
                chk("idle_beat", int'(beat), 0);
                chk("idle_done", int'(done), 0);
                chk("idle_err", int'(err_timeout), 0);
                chk("idle_req", int'(req), 0);
            end
            if (cmd_valid && cmd_ready) begin
                if (m_active) chk("accept_while_busy", int'(cmd_ready), 0);
                m_active = 1'b1;
                m_idx    = 0;
                m_beats  = 0;
                m_last   = -1;
            end
        end
    end

    initial begin : stim
        int guard;
        int len;
        // Reset, then a burst interrupted by reset after three beats.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        gnt = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_req", int'(req), 0);
        chk("rst_beat", int'(beat), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_timeout), 0);
        step();
        cmd_valid = 1'b1;
        cmd_len   = 4'd7;
        @(negedge clk);
        chk("rstb_accept_ready", int'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstb_req_up", int'(req), 1);
        chk("rstb_no_beat_req", int'(beat), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) rst = 1'b1;
            @(negedge clk);
            chk("rstb_beat", int'(beat), 1);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstb_req_drop", int'(req), 0);
        chk("rstb_beat_drop", int'(beat), 0);
        chk("rstb_no_done", int'(done), 0);
        step();
        gnt = 1'b0;
        @(negedge clk);
        chk("rstb_ready_after", int'(cmd_ready), 1);
        chk("rstb_req_after", int'(req), 0);
        chk("rstb_done_after", int'(done), 0);
        $display("txn reset-abort len=7 after 3 beats");

        mon_en = 1'b1;

        // Single beat, grant present from the first request cycle.
        pw = '{0, 1, 1, 1}; ph = '{64, 64, 64, 64};
        run_cmd(0, 1'b0, 2);
        // Four beats split 2 + 2 by a three-cycle grant loss.
        pw = '{0, 3, 1, 1}; ph = '{3, 64, 64, 64};
        run_cmd(3, 1'b0, 2);
        // Grant never comes.
        pw = '{100, 1, 1, 1}; ph = '{64, 64, 64, 64};
        run_cmd(5, 1'b0, 2);
        // Grant arrives exactly in the expiry cycle.
        pw = '{WAIT_MAX - 1, 1, 1, 1}; ph = '{64, 64, 64, 64};
        run_cmd(2, 1'b0, 2);
        // Back-to-back commands with cmd_valid held.
        pw = '{0, 1, 1, 1}; ph = '{64, 64, 64, 64};
        run_cmd(1, 1'b1, 0);
        run_cmd(1, 1'b1, 2);

        // Randomized commands and grant schedules.
        for (int n = 0; n < 150; n++) begin
            len   = $urandom_range(0, 15);
            pw[0] = $urandom_range(0, WAIT_MAX + 1);
            for (int k = 1; k < NSEG; k++) pw[k] = $urandom_range(1, WAIT_MAX + 2);
            for (int k = 0; k < NSEG - 1; k++) ph[k] = $urandom_range(1, 5);
            ph[NSEG-1] = 64;
            run_cmd(len, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Client-side agent for the 4-way request/grant arbiter. One instance sits in front of each bus master and drives one reqN line while consuming the matching gntN.
- Accepts burst commands from the local master and raises req. Waits for gnt, then counts out the granted beats.
- Releases req with a mandatory one-cycle gap so the arbiter can rotate. Reports completion, and reports a timeout if the grant never arrives.

Parameters:
- BURST_W, 4, width of cmd_len; a burst carries 1..2**BURST_W beats.
- WAIT_MAX, 64, cycles allowed in REQ without a grant before abort (range 1..65535).
- WAIT_W, 16, width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  master presents a burst command.
- cmd_len  in  BURST_W  beats minus 1.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- gnt  in  1  grant from the arbiter (gntN).
- req  out  1  request to the arbiter (reqN); registered.
- beat  out  1  bus owned this cycle; the master transfers one beat.
- done  out  1  one-cycle pulse: burst completed.
- err_timeout  out  1  one-cycle pulse: grant wait exceeded WAIT_MAX; the burst is dropped.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, req=0, done=0, err_timeout=0, beat count=0, wait count=0. cmd_ready=1 and beat=0 in the cycle after rst falls.
- A rst asserted mid-burst aborts on the next edge: req drops immediately and no done pulse is generated.

States (FSM) and transitions:
- IDLE
  - cmd_ready=1, req=0.
  - On cmd_valid: latch cmd_len into remaining count, clear wait count, go to REQ. req=1 from the next cycle (accept at edge T gives req high in cycle T+1).
- REQ
  - req=1, cmd_ready=0.
  - gnt=1: go to OWN at the next edge; the wait counter is held.
  - gnt=0: wait count +1. When wait count reaches WAIT_MAX-1 with gnt still 0: err_timeout=1 next cycle, req=0 next cycle, go to IDLE.
  - gnt and timeout in the same cycle: gnt wins and there is no error.
- OWN
  - req=1, beat = gnt (combinational AND with state==OWN).
  - Each cycle with gnt=1: one beat is consumed.
  - Last beat (remaining=0) with gnt=1: go to RELEASE, req=0 next cycle.
  - Otherwise with gnt=1: remaining -1.
  - gnt=0 mid-burst (preemption): no beat that cycle, remaining kept, wait count cleared, go to REQ. The burst resumes when the grant returns.
- RELEASE
  - req=0, done=1 for exactly this cycle, cmd_ready=0.
  - Always go to IDLE. Minimum req-low gap between bursts is therefore 2 cycles (RELEASE plus IDLE accept).

Other rules:
- Total beats per command = cmd_len+1, no more and no less, regardless of preemptions.
- Remaining count is BURST_W bits. It never wraps, because it is never decremented at 0.
- Wait counter saturates at WAIT_MAX-1 and is cleared on entry to REQ.
- gnt while in IDLE or RELEASE is ignored: no beat is produced.
- cmd_valid while not in IDLE is ignored (cmd_ready=0). The command must be held by the master.

Decomposition:
- Shared package arb_pkg holds:
  - the state typedef (IDLE, REQ, OWN, RELEASE, 2-bit encoding);
  - NUM_REQ=4;
  - default BURST_W and WAIT_MAX constants, reused by the arbiter and its bench.
- One natural sub-module: arb_wait_timer, a clear/enable/saturate counter asserting expire at WAIT_MAX-1. The FSM and beat counter stay in arb_requester.

Test Plan:
- Reset mid-OWN with cmd_len=7 after 3 beats -> req=0 and beat=0 next cycle, no done pulse, cmd_ready=1 afterwards.
- cmd_len=0, gnt tied high from the cycle after req rises -> exactly 1 beat; done pulses 1 cycle after the beat; req high for exactly 2 cycles.
- cmd_len=3, gnt high 2 cycles, low 3, high again -> 4 beats total: 2, then gap, then 2; req stays high through the gap; one done.
- WAIT_MAX=4, gnt never asserted -> req high 4 cycles, err_timeout single pulse, no beat, no done, back to IDLE.
- gnt rises in the same cycle the wait counter expires (WAIT_MAX=4) -> OWN entered, no err_timeout, burst completes normally.
- Two back-to-back commands (cmd_len=1 each), cmd_valid held high -> 2 beats, done, req low for 2 cycles, then the second burst's 2 beats, then a second done.
